// File: rtl/braille_cell_entry.sv
// Capture stage for braille cells: synchronizes the dot switches and commit key, debounces the key
// and queues one 6-bit cell per press in a FIFO drained over valid/ready. Define BRL_EMPTY_REJECT_EN to drop blank cells.
module braille_cell_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEPTH           = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [5:0]                 dots,
  input  logic                       key_n,
  output logic [5:0]                 letra,
  output logic                       letra_valid,
  input  logic                       letra_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [1:0]                 debug_state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] REL_WAIT   = 2'd3;

  localparam logic [CW-1:0]   LOAD = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  // Handshake: an entry transfers on any cycle where letra_valid and letra_ready are both high;
  // letra_valid depends on registered occupancy only, never on letra_ready.

  logic       key_meta, key_s;
  logic [5:0] dots_meta, dots_s;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_meta  <= 1'b1;
      key_s     <= 1'b1;
      dots_meta <= 6'b000000;
      dots_s    <= 6'b000000;
    end else begin
      key_meta  <= key_n;
      key_s     <= key_meta;
      dots_meta <= dots;
      dots_s    <= dots_meta;
    end
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          commit;

  // The commit cycle is the one where the counter steps from 1 to 0, i.e. t + DEBOUNCE_CYCLES - 1.
  assign commit      = !reset && (state == PRESS_WAIT) && !key_s && (cnt == CW'(1));
  assign debug_state = state;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!key_s) begin
            cnt   <= LOAD;
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= HELD;
          end
        end
        HELD: begin
          if (key_s) begin
            cnt   <= LOAD;
            state <= REL_WAIT;
          end
        end
        default: begin
          if (!key_s) begin
            state <= HELD;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= IDLE;
          end
        end
      endcase
    end
  end

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          cell_ok, pop, push, drop;

`ifdef BRL_EMPTY_REJECT_EN
  assign cell_ok = (dots_s != 6'b000000);
`else
  assign cell_ok = 1'b1;
`endif

  assign pop  = (count != '0) && letra_ready;
  assign push = commit && cell_ok && ((count != FULL) || pop);
  assign drop = commit && cell_ok && (count == FULL) && !pop;

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= dots_s;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign letra_valid = (count != '0);
  assign letra       = letra_valid ? mem[rd_ptr] : 6'b000000;

endmodule

// File: tb/tb_braille_cell_entry.sv
// Directed bench for braille_cell_entry with DEBOUNCE_CYCLES=4 and DEPTH=8.
module tb_braille_cell_entry;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HELD = 2'd2;

  logic       clk;
  logic       reset;
  logic [5:0] dots;
  logic       key_n;
  logic [5:0] letra;
  logic       letra_valid;
  logic       letra_ready;
  logic [3:0] count;
  logic       overflow;
  logic [1:0] debug_state;

  int checks = 0;
  int errors = 0;

  braille_cell_entry #(.DEBOUNCE_CYCLES(4), .DEPTH(8)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .dots        (dots),
    .key_n       (key_n),
    .letra       (letra),
    .letra_valid (letra_valid),
    .letra_ready (letra_ready),
    .count       (count),
    .overflow    (overflow),
    .debug_state (debug_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0] dots;
    logic [3:0] exp_count;
    logic [5:0] exp_letra;
    logic       exp_overflow;
  } vec_t;

  vec_t vec [9];
  logic [5:0] exp_q [$];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_n = 1'b1;
    letra_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // dots settle, key low 12 cycles, key high 12 cycles
  task automatic press(input logic [5:0] d);
    dots = d;
    tick(3);
    key_n = 1'b0;
    tick(12);
    key_n = 1'b1;
    tick(12);
  endtask

  initial begin
    reset = 1'b1;
    dots = 6'b000000;
    key_n = 1'b1;
    letra_ready = 1'b0;

    for (int i = 0; i < 8; i++)
      vec[i] = '{dots: 6'(i + 1), exp_count: 4'(i + 1), exp_letra: 6'd1, exp_overflow: 1'b0};
    vec[8] = '{dots: 6'd9, exp_count: 4'd8, exp_letra: 6'd1, exp_overflow: 1'b1};

    // reset state
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_count", count, 0);
    check("rst_valid", letra_valid, 0);
    check("rst_letra", letra, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", debug_state, S_IDLE);

    // 1: single clean press, latency
    dots = 6'b000001;
    tick(3);
    key_n = 1'b0;
    tick(5);
    check("t1_before_valid", letra_valid, 0);
    check("t1_before_count", count, 0);
    tick(1);
    check("t1_valid", letra_valid, 1);
    check("t1_letra", letra, 6'b000001);
    check("t1_count", count, 1);
    check("t1_state_held", debug_state, S_HELD);
    dots = 6'h3f;
    tick(6);
    key_n = 1'b1;
    tick(12);
    check("t1_final_count", count, 1);
    check("t1_letra_kept", letra, 6'b000001);
    check("t1_state_idle", debug_state, S_IDLE);

    // 2: bouncy key
    do_reset();
    dots = 6'b000101;
    tick(3);
    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(10);
    check("t2_count", count, 0);
    check("t2_valid", letra_valid, 0);
    check("t2_state", debug_state, S_IDLE);

    // 3: fill and overflow, table-driven
    do_reset();
    for (int i = 0; i < 9; i++) begin
      press(vec[i].dots);
      check($sformatf("t3_count_%0d", i), count, vec[i].exp_count);
      check($sformatf("t3_letra_%0d", i), letra, vec[i].exp_letra);
      check($sformatf("t3_valid_%0d", i), letra_valid, 1);
      check($sformatf("t3_overflow_%0d", i), overflow, vec[i].exp_overflow);
    end

    // 5: reset during PRESS_WAIT with key held low
    dots = 6'b000011;
    tick(3);
    key_n = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_count", count, 0);
    check("t5_overflow", overflow, 0);
    check("t5_state", debug_state, S_IDLE);
    tick(5);
    check("t5_no_early_commit", count, 0);
    tick(1);
    check("t5_commit_count", count, 1);
    check("t5_commit_letra", letra, 6'b000011);
    key_n = 1'b1;
    tick(12);

    // 4: commit on a full FIFO while the head is popped
    do_reset();
    exp_q.delete();
    for (int i = 1; i <= 8; i++) press(6'(i));
    check("t4_full", count, 8);
    for (int i = 2; i <= 9; i++) exp_q.push_back(6'(i));
    dots = 6'd9;
    tick(3);
    key_n = 1'b0;
    tick(5);
    letra_ready = 1'b1;
    tick(1);
    letra_ready = 1'b0;
    check("t4_count_same", count, 8);
    check("t4_overflow", overflow, 0);
    tick(6);
    key_n = 1'b1;
    tick(12);
    letra_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [5:0] e;
      e = exp_q.pop_front();
      check("t4_drain_valid", letra_valid, 1);
      check("t4_drain_letra", letra, e);
      tick(1);
    end
    letra_ready = 1'b0;
    check("t4_empty_count", count, 0);
    check("t4_empty_valid", letra_valid, 0);
    check("t4_empty_letra", letra, 0);

    // 6: blank cell
    do_reset();
    press(6'b000000);
`ifdef BRL_EMPTY_REJECT_EN
    check("t6_count", count, 0);
    check("t6_valid", letra_valid, 0);
`else
    check("t6_count", count, 1);
    check("t6_valid", letra_valid, 1);
`endif
    check("t6_letra", letra, 0);
    check("t6_overflow", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/braille_cell_entry.md
# braille_cell_entry

Upstream capture stage for the braille-to-7-segment letter decoder. Samples the six dot switches when the user presses a commit key. Debounces the key and issues exactly one commit per physical press. Queues the captured 6-bit cells in a small FIFO, which the decoder drains through a valid/ready handshake.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles the synchronized key must stay stable before a press or release is accepted (20 ms at 50 MHz). Must be ≥2.
- DEPTH, 8: FIFO entries. Must be a power of two, ≥2.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, only clock in the block
- reset  in  1  synchronous, active-high; acts on the CLOCK_50 rising edge
- dots  in  6  raw dot switches, asynchronous; bit0 = dot 1 … bit5 = dot 6, same encoding the decoder's letra input uses
- key_n  in  1  raw commit push-button, active-low, asynchronous, bouncy
- letra  out  6  cell at FIFO head; 6'b000000 when empty
- letra_valid  out  1  FIFO non-empty
- letra_ready  in  1  consumer accepts head this cycle
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- overflow  out  1  sticky; set when a commit is dropped because the FIFO is full

## Operation

- **Synchronizers:** two-flop synchronizer on key_n, giving key_s. Two-flop synchronizer on each dots bit, giving dots_s. All logic uses the synchronized signals only.
- **Debounce FSM:** one down-counter, states IDLE, PRESS_WAIT, HELD, REL_WAIT.
  - IDLE: when key_s = 0, load counter with DEBOUNCE_CYCLES-1 and go to PRESS_WAIT.
  - PRESS_WAIT: key_s = 1 returns to IDLE with no commit. Counter reaching 0 with key_s = 0 produces a 1-cycle commit pulse, captures dots_s that same cycle, and goes to HELD.
  - HELD: when key_s = 1, reload counter and go to REL_WAIT.
  - REL_WAIT: key_s = 0 returns to HELD. Counter reaching 0 goes to IDLE.
- Holding the key indefinitely produces no further commits (no auto-repeat).
- **FIFO:** circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap naturally, plus a count register.
  - Pop occurs when letra_valid and letra_ready. Pop with count = 0 is ignored.
  - Push occurs on commit if count < DEPTH, or if count = DEPTH and a pop happens the same cycle.
  - Commit with the FIFO full and no pop: cell dropped, overflow ← 1, count unchanged.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
- letra = mem[rd_ptr] when count > 0, else 6'b000000. letra_valid = (count ≠ 0).
- overflow is cleared only by reset.

## Timing

- Reset values:
  - FSM = IDLE, counter = 0, pointers = 0, count = 0
  - letra = 6'b000000, letra_valid = 0, overflow = 0
  - synchronizer flops = idle level: key 1, dots 0
- Reset asserted mid-operation, in any state, aborts it. No commit fires in the reset cycle. FIFO contents are discarded.
- Let t be the first cycle key_s = 0 (t = raw key_n fall + 2 cycles).
  - commit at t + DEBOUNCE_CYCLES - 1 if key_s stayed 0.
  - letra_valid rises at t + DEBOUNCE_CYCLES when the FIFO was empty.
- Cell captured = dots_s in the commit cycle. Dots changes later do not affect queued entries.
- Pop takes effect at the next edge. The new head is visible one cycle after the accepting cycle.
- count, letra_valid and overflow are registered or derive from registered state only. No combinational path exists from letra_ready to letra_valid.

## Configuration

- BRL_EMPTY_REJECT_EN defined: a commit whose captured cell is 6'b000000 is discarded, with no push and no overflow effect. The FSM still goes to HELD.
- BRL_EMPTY_REJECT_EN undefined: 6'b000000 is queued like any other cell (space character).

## Test plan

Bench uses DEBOUNCE_CYCLES=4, DEPTH=8.

1. After reset, dots=6'b000001, key_n low 12 cycles then high 12 cycles → exactly one entry; letra=6'b000001, letra_valid=1, count=1 at t+4.
2. key_n bounces low 2 / high 1 / low 2 / high → no commit, count=0, FSM back in IDLE.
3. letra_ready=0, eight clean presses with dots=1..8 → count=8. Ninth press → count=8, overflow=1, letra=6'b000001.
4. FIFO full, letra_ready=1 in the same cycle a commit fires → count stays 8. Draining yields 2..8 then the new cell, in order.
5. Reset pulsed during PRESS_WAIT, key kept low → no commit; count=0, overflow=0. A fresh 4-cycle hold is needed before the next commit.
6. dots=6'b000000, clean press → count stays 0 with BRL_EMPTY_REJECT_EN defined; count=1 with letra=6'b000000 without it.
